// File: rtl/multiplier_seq_ll.sv
// Sequential shift-add multiply-accumulator: P = A*B + C, one result every BITS+1 cycles.
// Also rebuilds a dividend from {quotient, divisor, remainder} for divider self-check.
module multiplier_seq_ll #(
    parameter int BITS = 32
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Start,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic [BITS-1:0] C,
    input  logic            Zero_a,
    input  logic            Zero_b,
    input  logic            Sign_a,
    input  logic            Sign_b,
    output logic            Busy,
    output logic            Done,
    output logic [BITS-1:0] P_hi,
    output logic [BITS-1:0] P_lo,
    output logic            Turn,
    output logic            Zero_p
);

    // state | meaning
    // IDLE  | waiting for Start, last result held on outputs
    // RUN   | one shift-add step per cycle, BITS cycles total
    // DONE  | result valid for one cycle, Start accepted back-to-back
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(BITS) + 1;

    state_t          state, state_nxt;
    logic [BITS-1:0] mcand;
    logic [BITS:0]   hi;
    logic [BITS-1:0] lo;
    logic [CW-1:0]   counter;
    logic            turn_q;
    logic            accept;
    logic            shortcut;
    logic            last;
    logic [BITS:0]   sum;

    always_comb begin
        accept    = 1'b0;
        shortcut  = Zero_a | Zero_b;
        last      = (counter == CW'(BITS - 1));
        sum       = hi + (lo[0] ? {1'b0, mcand} : '0);
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = shortcut ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            counter <= '0;
            turn_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand   <= A;
                turn_q  <= Sign_a ^ Sign_b;
                counter <= '0;
                // Zero operand: skip the loop, the result is just the addend
                if (shortcut) begin
                    hi <= '0;
                    lo <= C;
                end else begin
                    hi <= {1'b0, C};
                    lo <= B;
                end
            end else if (state == RUN) begin
                hi      <= {1'b0, sum[BITS:1]};
                lo      <= {sum[0], lo[BITS-1:1]};
                counter <= counter + CW'(1);
            end
        end
    end

    // hi[BITS] cannot be set once the loop finishes, so it is left off the result
    always_comb begin
        Busy   = (state == RUN);
        Done   = (state == DONE);
        P_hi   = hi[BITS-1:0];
        P_lo   = lo;
        Turn   = turn_q;
        Zero_p = ~|{hi[BITS-1:0], lo};
    end

endmodule

// File: tb/tb_multiplier_seq_ll.sv
// Scoreboard bench for multiplier_seq_ll at BITS=8: stimulus pushes expectations,
// a monitor pops and compares on every Done.
module tb_multiplier_seq_ll;

    localparam int BITS = 8;

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic            Start;
    logic [BITS-1:0] A, B, C;
    logic            Zero_a, Zero_b, Sign_a, Sign_b;
    logic            Busy, Done, Turn, Zero_p;
    logic [BITS-1:0] P_hi, P_lo;

    typedef struct {
        logic [2*BITS-1:0] p;
        logic              turn;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    multiplier_seq_ll #(.BITS(BITS)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
        .A(A), .B(B), .C(C),
        .Zero_a(Zero_a), .Zero_b(Zero_b), .Sign_a(Sign_a), .Sign_b(Sign_b),
        .Busy(Busy), .Done(Done), .P_hi(P_hi), .P_lo(P_lo),
        .Turn(Turn), .Zero_p(Zero_p)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [BITS-1:0] a, b, c, input logic za, zb, sa, sb_);
        exp_t e;
        e.p    = (za | zb) ? {8'h00, c} : (16'(a) * 16'(b) + 16'(c));
        e.turn = sa ^ sb_;
        sb.push_back(e);
    endtask

    // Monitor: every Done must match the oldest outstanding expectation
    always @(negedge Clk) begin
        if (Rst_n && Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=P 0x%0h required=no Done", {P_hi, P_lo});
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", 32'({P_hi, P_lo}), 32'(e.p));
                chk("turn", 32'(Turn), 32'(e.turn));
                chk("zero_p", 32'(Zero_p), 32'(e.p == '0));
            end
        end
    end

    task automatic op(input logic [BITS-1:0] a, b, c, input logic za, zb, sa, sb_);
        int n;
        int busy_n;
        int lat;
        lat = (za | zb) ? 1 : BITS + 1;
        @(negedge Clk);
        A = a; B = b; C = c; Zero_a = za; Zero_b = zb; Sign_a = sa; Sign_b = sb_;
        Start = 1'b1;
        push_exp(a, b, c, za, zb, sa, sb_);
        @(negedge Clk);
        Start = 1'b0;
        A = 8'hA5; B = 8'h5A; C = 8'h3C;
        n = 1;
        busy_n = 0;
        while (!Done && n < 50) begin
            if (Busy) busy_n++;
            @(negedge Clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("busy_cycles", 32'(busy_n), 32'(lat - 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n, m;
        Rst_n = 1'b0; Start = 1'b0;
        A = '0; B = '0; C = '0;
        Zero_a = 1'b0; Zero_b = 1'b0; Sign_a = 1'b0; Sign_b = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_p", 32'({P_hi, P_lo}), 0);
        chk("rst_turn", 32'(Turn), 0);
        chk("rst_zero_p", 32'(Zero_p), 1);
        Rst_n = 1'b1;

        op(8'd13,  8'd11,  8'd5,   0, 0, 0, 0);   // 0x0094
        op(8'd255, 8'd255, 8'd254, 0, 0, 1, 0);   // 0xFEFF, Turn=1
        op(8'd9,   8'd0,   8'd7,   0, 1, 0, 0);   // shortcut -> 7
        op(8'd9,   8'd0,   8'd0,   0, 1, 1, 1);   // shortcut -> 0, Zero_p
        op(8'd0,   8'd5,   8'd3,   1, 0, 0, 1);   // shortcut via Zero_a
        op(8'd28,  8'd7,   8'd4,   0, 0, 1, 1);   // 200/7 = 28 r 4
        op(8'd15,  8'd16,  8'd15,  0, 0, 0, 0);   // 255/16 = 15 r 15
        op(8'd128, 8'd2,   8'd0,   0, 0, 0, 1);   // 0x0100
        op(8'd255, 8'd1,   8'd255, 0, 0, 0, 0);   // 0x01FE
        op(8'd1,   8'd1,   8'd0,   0, 0, 0, 0);

        // Start held high: back-to-back ops, then an ignored pulse in RUN
        @(negedge Clk);
        A = 8'd3; B = 8'd4; C = 8'd0; Zero_a = 0; Zero_b = 0; Sign_a = 0; Sign_b = 0;
        Start = 1'b1;
        push_exp(8'd3, 8'd4, 8'd0, 0, 0, 0, 0);
        @(negedge Clk);
        A = 8'd6; B = 8'd7; C = 8'd1;
        push_exp(8'd6, 8'd7, 8'd1, 0, 0, 0, 0);
        n = 1;
        while (!Done && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("b2b_first_latency", 32'(n), 32'(BITS + 1));
        @(negedge Clk);
        chk("b2b_done_drop", 32'(Done), 0);
        chk("b2b_busy_rise", 32'(Busy), 1);
        m = 1;
        while (!Done && m < 50) begin
            if (m == 4) begin
                Start = 1'b1; A = 8'd99; B = 8'd99; C = 8'd99; Sign_a = 1'b1;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
            m++;
        end
        Start = 1'b0;
        chk("b2b_spacing", 32'(m), 32'(BITS + 1));

        // Reset in the middle of a run: no Done, outputs return to reset values at once
        @(negedge Clk);
        A = 8'd200; B = 8'd200; C = 8'd0; Sign_a = 1'b1; Sign_b = 1'b0;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_done", 32'(Done), 0);
        chk("abort_p", 32'({P_hi, P_lo}), 0);
        chk("abort_turn", 32'(Turn), 0);
        chk("abort_zero_p", 32'(Zero_p), 1);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (12) @(negedge Clk);
        op(8'd2, 8'd3, 8'd1, 0, 0, 0, 0);         // 7

        for (int i = 0; i < 20; i++) begin
            op(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
               8'($urandom_range(0, 255)), 0, 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
